// File: rtl/gray_conv_param.sv
// RGB-to-luma converter with frame-synchronous config,
// 4-stage fixed pipeline, binarisation and per-frame min/max stats.
module gray_conv_param #(
  parameter int R_W    = 5,
  parameter int G_W    = 6,
  parameter int B_W    = 5,
  parameter int OUT_W  = 8,
  parameter bit VS_POL = 1'b1
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     de_flag,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic [R_W+G_W+B_W-1:0]   data_rgb,
  input  logic [1:0]               cfg_mode,
  input  logic                     cfg_bin_en,
  input  logic [OUT_W-1:0]         cfg_thresh,
  output logic                     de_flag_gray,
  output logic                     hsync_gray,
  output logic                     vsync_gray,
  output logic [OUT_W-1:0]         data_gray,
  output logic [15:0]              data_gray_r,
  output logic                     bin_out,
  output logic [OUT_W-1:0]         stat_min,
  output logic [OUT_W-1:0]         stat_max,
  output logic                     stat_valid
);

  localparam int IN_W = R_W + G_W + B_W;
  localparam int PW   = OUT_W + 9;
  localparam int SW   = OUT_W + 10;
  localparam int RR   = OUT_W / R_W + 1;
  localparam int GR   = OUT_W / G_W + 1;
  localparam int BR   = OUT_W / B_W + 1;
  localparam logic [OUT_W-1:0] TH0 = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [SW-1:0]    RND = SW'(128);

  logic             vs_prev;
  logic             fs_in;
  logic [1:0]       act_mode;
  logic             act_bin;
  logic [OUT_W-1:0] act_th;
  logic [1:0]       eff_mode;
  logic             eff_bin;
  logic [OUT_W-1:0] eff_th;

  assign fs_in    = (vsync == VS_POL) && (vs_prev != VS_POL);
  assign eff_mode = fs_in ? cfg_mode   : act_mode;
  assign eff_bin  = fs_in ? cfg_bin_en : act_bin;
  assign eff_th   = fs_in ? cfg_thresh : act_th;

  // MSB replication: repeat the channel, keep the top OUT_W bits
  logic [RR*R_W-1:0] r_rep;
  logic [GR*G_W-1:0] g_rep;
  logic [BR*B_W-1:0] b_rep;
  logic [OUT_W-1:0]  r_x, g_x, b_x;

  assign r_rep = {RR{data_rgb[IN_W-1 -: R_W]}};
  assign g_rep = {GR{data_rgb[B_W +: G_W]}};
  assign b_rep = {BR{data_rgb[B_W-1:0]}};
  assign r_x   = OUT_W'(r_rep >> (RR*R_W - OUT_W));
  assign g_x   = OUT_W'(g_rep >> (GR*G_W - OUT_W));
  assign b_x   = OUT_W'(b_rep >> (BR*B_W - OUT_W));

  logic [OUT_W-1:0] r1, g1, b1, th1, th2, th3;
  logic [1:0]       mode1;
  logic             bin1, bin2, bin3;
  logic [PW-1:0]    pr2, pg2, pb2;
  logic [SW-1:0]    sum3;
  logic [3:0]       de_d, hs_d, vs_d;
  logic [OUT_W-1:0] y_q;

  logic [8:0] cr, cg, cb;

  always_comb begin
    cr = '0;
    cg = '0;
    cb = '0;
    unique case (1'b1)
      (mode1 == 2'd0): begin cr = 9'd77; cg = 9'd150; cb = 9'd29; end
      (mode1 == 2'd1): begin cr = 9'd54; cg = 9'd183; cb = 9'd19; end
      (mode1 == 2'd2): begin cr = 9'd85; cg = 9'd85;  cb = 9'd85; end
      (mode1 == 2'd3): begin cg = 9'd256; end
    endcase
  end

  logic [OUT_W+1:0] y_full;
  logic [OUT_W-1:0] y_sat;
  logic [OUT_W-1:0] gray_nx;

  assign y_full  = (OUT_W+2)'(sum3 >> 8);
  assign y_sat   = (|y_full[OUT_W+1:OUT_W]) ? {OUT_W{1'b1}}
                                            : y_full[OUT_W-1:0];
  assign gray_nx = !bin3 ? y_sat :
                   (y_sat >= th3) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  // Flushed stages carry the reset threshold so bin_out stays low
  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_prev     <= 1'b0;
      act_mode    <= 2'd0;
      act_bin     <= 1'b0;
      act_th      <= TH0;
      r1          <= '0;
      g1          <= '0;
      b1          <= '0;
      mode1       <= 2'd0;
      bin1        <= 1'b0;
      th1         <= TH0;
      pr2         <= '0;
      pg2         <= '0;
      pb2         <= '0;
      bin2        <= 1'b0;
      th2         <= TH0;
      sum3        <= '0;
      bin3        <= 1'b0;
      th3         <= TH0;
      y_q         <= '0;
      data_gray   <= '0;
      data_gray_r <= '0;
      bin_out     <= 1'b0;
      de_d        <= '0;
      hs_d        <= '0;
      vs_d        <= '0;
    end else begin
      vs_prev  <= vsync;
      act_mode <= eff_mode;
      act_bin  <= eff_bin;
      act_th   <= eff_th;
      r1       <= r_x;
      g1       <= g_x;
      b1       <= b_x;
      mode1    <= eff_mode;
      bin1     <= eff_bin;
      th1      <= eff_th;
      pr2      <= {{(PW-OUT_W){1'b0}}, r1} * {{(PW-9){1'b0}}, cr};
      pg2      <= {{(PW-OUT_W){1'b0}}, g1} * {{(PW-9){1'b0}}, cg};
      pb2      <= {{(PW-OUT_W){1'b0}}, b1} * {{(PW-9){1'b0}}, cb};
      bin2     <= bin1;
      th2      <= th1;
      sum3     <= {1'b0, pr2} + {1'b0, pg2} + {1'b0, pb2} + RND;
      bin3     <= bin2;
      th3      <= th2;
      y_q      <= y_sat;
      data_gray   <= gray_nx;
      data_gray_r <= {gray_nx[OUT_W-1 -: 5],
                      gray_nx[OUT_W-1 -: 6],
                      gray_nx[OUT_W-1 -: 5]};
      bin_out  <= (y_sat >= th3);
      de_d     <= {de_d[2:0], de_flag};
      hs_d     <= {hs_d[2:0], hsync};
      vs_d     <= {vs_d[2:0], vsync};
    end
  end

  assign de_flag_gray = de_d[3];
  assign hsync_gray   = hs_d[3];
  assign vsync_gray   = vs_d[3];

  logic             vsg_prev;
  logic             fs_out;
  logic [OUT_W-1:0] acc_min, acc_max;

  assign fs_out = (vsync_gray == VS_POL) && (vsg_prev != VS_POL);

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsg_prev   <= 1'b0;
      acc_min    <= {OUT_W{1'b1}};
      acc_max    <= '0;
      stat_min   <= '0;
      stat_max   <= '0;
      stat_valid <= 1'b0;
    end else begin
      vsg_prev   <= vsync_gray;
      stat_valid <= fs_out;
      if (fs_out) begin
        stat_min <= acc_min;
        stat_max <= acc_max;
        acc_min  <= de_flag_gray ? y_q : {OUT_W{1'b1}};
        acc_max  <= de_flag_gray ? y_q : {OUT_W{1'b0}};
      end else if (de_flag_gray) begin
        if (y_q < acc_min) acc_min <= y_q;
        if (y_q > acc_max) acc_max <= y_q;
      end
    end
  end

endmodule

// File: tb/tb_gray_conv_param.sv
// Bench for gray_conv_param: arithmetic luma model plus
// directed literal cases and randomized frames.
module tb_gray_conv_param;

  logic        pclk = 1'b0;
  logic        rst;
  logic        de_flag, hsync, vsync;
  logic [15:0] data_rgb;
  logic [1:0]  cfg_mode;
  logic        cfg_bin_en;
  logic [7:0]  cfg_thresh;
  logic        de_flag_gray, hsync_gray, vsync_gray;
  logic [7:0]  data_gray;
  logic [15:0] data_gray_r;
  logic        bin_out;
  logic [7:0]  stat_min, stat_max;
  logic        stat_valid;

  always #5 pclk = ~pclk;

  gray_conv_param dut (
    .pclk(pclk), .rst(rst),
    .de_flag(de_flag), .hsync(hsync), .vsync(vsync),
    .data_rgb(data_rgb),
    .cfg_mode(cfg_mode), .cfg_bin_en(cfg_bin_en),
    .cfg_thresh(cfg_thresh),
    .de_flag_gray(de_flag_gray), .hsync_gray(hsync_gray),
    .vsync_gray(vsync_gray),
    .data_gray(data_gray), .data_gray_r(data_gray_r),
    .bin_out(bin_out),
    .stat_min(stat_min), .stat_max(stat_max),
    .stat_valid(stat_valid)
  );

  typedef struct {
    int de; int hs; int vs;
    int y; int gray; int g565; int bo;
  } ent_t;

  ent_t pipe[4];
  int   m_vs_prev, m_mode, m_bin, m_th;
  int   m_vsg_prev, acc_min, acc_max;
  int   st_min, st_max, st_valid;
  int   errs = 0;
  int   checks = 0;

  int coef_r[4] = '{77, 54, 85, 0};
  int coef_g[4] = '{150, 183, 85, 256};
  int coef_b[4] = '{29, 19, 85, 0};

  function automatic int luma(int rgb, int mode);
    int r, g, b, r8, g8, b8, y;
    r  = (rgb >> 11) & 31;
    g  = (rgb >> 5) & 63;
    b  = rgb & 31;
    r8 = (r << 3) | (r >> 2);
    g8 = (g << 2) | (g >> 4);
    b8 = (b << 3) | (b >> 2);
    y  = (r8 * coef_r[mode] + g8 * coef_g[mode]
          + b8 * coef_b[mode] + 128) / 256;
    return (y > 255) ? 255 : y;
  endfunction

  task automatic model_step();
    ent_t e;
    int   o;
    if (rst) begin
      m_vs_prev = 0; m_mode = 0; m_bin = 0; m_th = 128;
      m_vsg_prev = 0; acc_min = 255; acc_max = 0;
      st_min = 0; st_max = 0; st_valid = 0;
      for (int i = 0; i < 4; i++) pipe[i] = '{0, 0, 0, 0, 0, 0, 0};
      return;
    end
    o = pipe[3].y;
    st_valid = 0;
    if (pipe[3].vs == 1 && m_vsg_prev == 0) begin
      st_min = acc_min; st_max = acc_max; st_valid = 1;
      acc_min = pipe[3].de ? o : 255;
      acc_max = pipe[3].de ? o : 0;
    end else if (pipe[3].de == 1) begin
      if (o < acc_min) acc_min = o;
      if (o > acc_max) acc_max = o;
    end
    m_vsg_prev = pipe[3].vs;
    if (vsync && m_vs_prev == 0) begin
      m_mode = int'(cfg_mode);
      m_bin  = int'(cfg_bin_en);
      m_th   = int'(cfg_thresh);
    end
    m_vs_prev = int'(vsync);
    e.de = int'(de_flag); e.hs = int'(hsync); e.vs = int'(vsync);
    e.y  = luma(int'(data_rgb), m_mode);
    e.bo = (e.y >= m_th) ? 1 : 0;
    e.gray = m_bin ? (e.bo ? 255 : 0) : e.y;
    e.g565 = ((e.gray >> 3) << 11) | ((e.gray >> 2) << 5) | (e.gray >> 3);
    for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = e;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
    check("de_flag_gray", int'(de_flag_gray), pipe[3].de);
    check("hsync_gray", int'(hsync_gray), pipe[3].hs);
    check("vsync_gray", int'(vsync_gray), pipe[3].vs);
    check("data_gray", int'(data_gray), pipe[3].gray);
    check("data_gray_r", int'(data_gray_r), pipe[3].g565);
    check("bin_out", int'(bin_out), pipe[3].bo);
    check("stat_min", int'(stat_min), st_min);
    check("stat_max", int'(stat_max), st_max);
    check("stat_valid", int'(stat_valid), st_valid);
  endtask

  task automatic drive(input int rgb, input bit de,
                       input bit hs, input bit vs);
    data_rgb = 16'(rgb);
    de_flag  = de;
    hsync    = hs;
    vsync    = vs;
  endtask

  task automatic px_lat(input int rgb, input bit vs);
    drive(rgb, 1'b1, 1'b0, vs);
    tick();
    drive(0, 1'b0, 1'b0, vs);
    repeat (3) tick();
  endtask

  int seen;

  initial begin
    rst = 1'b1;
    cfg_mode = 2'd0; cfg_bin_en = 1'b0; cfg_thresh = 8'd0;
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    check("reset_gray", int'(data_gray), 0);
    check("reset_stat_min", int'(stat_min), 0);
    rst = 1'b0;

    px_lat(16'hFFFF, 1'b0);
    check("white_gray", int'(data_gray), 8'hFF);
    check("white_565", int'(data_gray_r), 16'hFFFF);

    px_lat(16'hF800, 1'b0);
    check("red_601", int'(data_gray), 77);
    cfg_mode = 2'd1;
    px_lat(16'hF800, 1'b1);
    check("red_709", int'(data_gray), 54);

    cfg_mode = 2'd2;
    px_lat(16'hF800, 1'b1);
    check("midframe_hold", int'(data_gray), 54);
    drive(0, 1'b0, 1'b0, 1'b0);
    tick();
    px_lat(16'hF800, 1'b1);
    check("newframe_avg", int'(data_gray), 85);

    cfg_mode = 2'd2; cfg_bin_en = 1'b1; cfg_thresh = 8'd100;
    drive(0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(16'h1FC3, 1'b1, 1'b0, 1'b1); tick();
    drive(16'h37C0, 1'b1, 1'b0, 1'b1); tick();
    drive(16'h37E0, 1'b1, 1'b0, 1'b1); tick();
    drive(0, 1'b0, 1'b0, 1'b1); tick();
    check("bin_y99", int'(data_gray), 0);
    check("binout_y99", int'(bin_out), 0);
    tick();
    check("bin_y100", int'(data_gray), 255);
    check("binout_y100", int'(bin_out), 1);
    tick();
    check("bin_y101", int'(data_gray), 255);
    check("binout_y101", int'(bin_out), 1);

    cfg_mode = 2'd0; cfg_bin_en = 1'b0; cfg_thresh = 8'd128;
    drive(0, 1'b0, 1'b0, 1'b0); tick();
    drive(0, 1'b0, 1'b0, 1'b1);
    repeat (7) tick();
    drive(16'h000B, 1'b1, 1'b0, 1'b1); tick();
    drive(16'hFE80, 1'b1, 1'b0, 1'b1); tick();
    drive(16'h02E1, 1'b1, 1'b0, 1'b1); tick();
    drive(0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    drive(0, 1'b0, 1'b0, 1'b0); tick();
    drive(0, 1'b0, 1'b0, 1'b1); tick();
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (stat_valid) begin seen = 1; break; end
      tick();
    end
    check("stat_valid_seen", seen, 1);
    if (seen == 1) begin
      check("frame_min", int'(stat_min), 10);
      check("frame_max", int'(stat_max), 200);
      tick();
      check("stat_pulse_1cyc", int'(stat_valid), 0);
    end

    for (int k = 0; k < 5; k++) begin
      drive(int'($urandom_range(0, 16'hFFFF)), 1'b1, 1'b1, 1'b1);
      tick();
    end
    rst = 1'b1;
    tick();
    check("midrst_gray", int'(data_gray), 0);
    check("midrst_de", int'(de_flag_gray), 0);
    check("midrst_hs", int'(hsync_gray), 0);
    rst = 1'b0;
    drive(16'hFFFF, 1'b1, 1'b1, 1'b0); tick();
    drive(0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("de_lat3", int'(de_flag_gray), 0);
    tick();
    check("de_lat4", int'(de_flag_gray), 1);
    check("hs_lat4", int'(hsync_gray), 1);

    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_bin_en = 1'($urandom_range(0, 1));
      cfg_thresh = 8'($urandom_range(0, 255));
      data_rgb   = 16'($urandom_range(0, 16'hFFFF));
      de_flag    = ($urandom_range(0, 3) != 0);
      hsync      = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) vsync = ~vsync;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
